game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game-flow controller for space_invaders. It owns the game state machine (title, start countdown, play, player-hit freeze, game over, wave cleared). On every `frame` pulse during play it issues one-cycle update strobes to the player, laser, invader and collision datapaths in a fixed order. It replaces free-running per-block updates, so that every frame's sprite, collision and score activity is serialized and frozen outside play.

## Interface
Parameters:
- `START_FRAMES`, default 120: frames spent in START before PLAY.
- `HIT_FRAMES`, default 90: frames the game is frozen after a player hit.
- `INVADER_PERIOD`, default 32: frames between invader steps; legal range 4..255.
- `LAND_Y`, default 10'd440: invader bottom y at or beyond which the game is lost.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-low.
- `frame` input 1: one-cycle pulse, once per video frame.
- `shoot` input 1: debounced shoot button, level.
- `player_collision` input 1: one-cycle pulse, player hit.
- `invaders` input 55: alive mask, 1 = alive.
- `invaders_bottom` input 10: y of the lowest alive invader row.
- `lives` input 2: remaining lives from score_logic.
- `state` output 3: IDLE=0, START=1, PLAY=2, HIT=3, OVER=4, WIN=5.
- `player_en`, `laser_en`, `invader_en`, `collide_en` output 1 each: one-cycle update strobes.
- `game_rst` output 1: one-cycle pulse that reinitializes sprites, lives and score.

## Operation
- Shoot edge: registered `shoot_q`. A press is `shoot & ~shoot_q`.
- IDLE: on a press, pulse `game_rst` and go to START. Clear the frame counter.
- START: count `frame` pulses. When the count reaches START_FRAMES, go to PLAY and clear the invader divider.
- PLAY, per-frame sequence: a 3-bit phase counter runs from 0. The `frame` pulse starts phases 1..5.
  - Phase 1: `player_en`.
  - Phase 2: `laser_en`.
  - Phase 3: `invader_en`, only if the divider equals period−1. The divider then wraps to 0; otherwise it increments.
  - Phase 4: `collide_en`.
  - Phase 5: evaluate, then return to phase 0.
  - A `frame` pulse arriving while phase ≠ 0 is dropped.
- Phase 5 evaluation, in priority order:
  1. `invaders_bottom >= LAND_Y` → OVER.
  2. `invaders == 0` → WIN.
  3. Otherwise stay in PLAY.
- `player_collision` seen in any PLAY cycle is latched into `hit_pend`. At phase 5, `hit_pend` outranks WIN but not landing. It clears `hit_pend` and causes a transition to HIT.
- HIT: all strobes are held low. Count HIT_FRAMES frames, then:
  - `lives == 0` → OVER.
  - Otherwise → PLAY, with the phase counter reset.
- OVER and WIN: all strobes are low. On a press, pulse `game_rst` and go to START.
- Mutual exclusion: at most one of the four strobes is high in any cycle. No strobe is high outside PLAY.
- Frame counter: 8 bits, saturating. It is cleared on every state entry.

## Timing
- Reset values:
  - `state` = IDLE.
  - All strobes = 0.
  - `game_rst` = 0.
  - Phase, divider, frame counter, `hit_pend` and `shoot_q` = 0.
- All outputs are registered.
- With `frame` high in cycle t during PLAY, phase 0:
  - `player_en` at t+1.
  - `laser_en` at t+2.
  - `invader_en` at t+3 (if due).
  - `collide_en` at t+4.
  - `state` changes at t+6.
- Press in cycle t (IDLE/OVER/WIN): `game_rst` is high at t+1, and `state` = START at t+1.
- START → PLAY: `state` = PLAY in the cycle after the START_FRAMES-th frame pulse. The first strobe follows the next frame pulse.
- `player_collision` during phase 5 of the same cycle is honored in that evaluation.
- Asserting `rst` mid-sequence clears everything immediately. No strobe completes.

## Configuration
- `SPEEDUP_EN` defined: the invader period depends on the popcount of `invaders`:
  - ≥40 alive: INVADER_PERIOD.
  - 20–39 alive: INVADER_PERIOD/2.
  - 5–19 alive: INVADER_PERIOD/4.
  - <5 alive: 1 (step every frame).
  - The period is re-evaluated when the divider wraps.
- `SPEEDUP_EN` undefined: the period is the constant INVADER_PERIOD. No popcount logic is built.

## Test plan
- Reset release, press `shoot` → `game_rst` 1 cycle, `state`=1. After 120 frame pulses, `state`=2.
- PLAY, `frame` at t → `player_en`/`laser_en`/`collide_en` at t+1/t+2/t+4. With INVADER_PERIOD=32, `invader_en` fires on every 32nd frame only.
- PLAY, `player_collision` pulse, `lives`=2 → `state`=3, no strobes for 90 frames, then `state`=2. Repeat with `lives`=0 → `state`=4.
- `invaders`=0 at phase 5 → `state`=5. Press → `game_rst`, `state`=1. Landing: `invaders_bottom`=440 together with `invaders`=0 → `state`=4.
- `SPEEDUP_EN`, INVADER_PERIOD=32, 10 invaders alive → `invader_en` every 8 frames. 3 alive → every frame.
- `rst` low at phase 2 → all outputs 0 and `state`=0 asynchronously. `frame` pulse at phase 3 → dropped, no second sequence.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer
//   Top-level game-flow controller for space_invaders. Owns the game state
//   machine (IDLE, START countdown, PLAY, HIT freeze, OVER, WIN). During PLAY
//   each frame pulse launches a serialized sequence of one-cycle update
//   strobes: player, laser, invader (when the divider is due) and collision.
//   The last phase of the sequence evaluates landing, hit and wave clear.
//   All datapath activity is frozen outside PLAY.
//
// Optional feature:
//   SPEEDUP_EN - when defined, the invader step period shrinks as invaders
//                die. The popcount of the alive mask selects the period.
//                When undefined, the period is the constant INVADER_PERIOD.
//
// Ports:
//   clk              in  1   system clock
//   rst              in  1   asynchronous active-low reset
//   frame            in  1   one-cycle pulse per video frame
//   shoot            in  1   debounced shoot button (level)
//   player_collision in  1   one-cycle pulse, player hit
//   invaders         in  55  alive mask, 1 = alive
//   invaders_bottom  in  10  y of the lowest alive invader row
//   lives            in  2   remaining lives
//   state            out 3   IDLE=0 START=1 PLAY=2 HIT=3 OVER=4 WIN=5
//   player_en        out 1   player update strobe
//   laser_en         out 1   laser update strobe
//   invader_en       out 1   invader step strobe
//   collide_en       out 1   collision update strobe
//   game_rst         out 1   one-cycle reinit pulse for sprites, lives, score
module game_sequencer #(
  parameter int unsigned START_FRAMES   = 120,
  parameter int unsigned HIT_FRAMES     = 90,
  parameter int unsigned INVADER_PERIOD = 32,
  parameter logic [9:0]  LAND_Y         = 10'd440
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic        shoot,
  input  logic        player_collision,
  input  logic [54:0] invaders,
  input  logic [9:0]  invaders_bottom,
  input  logic [1:0]  lives,
  output logic [2:0]  state,
  output logic        player_en,
  output logic        laser_en,
  output logic        invader_en,
  output logic        collide_en,
  output logic        game_rst
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_HIT   = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;

  // The count compares against N-1 on the frame pulse, so the transition
  // lands in the cycle right after the N-th pulse.
  localparam logic [7:0] START_LAST  = 8'(START_FRAMES - 1);
  localparam logic [7:0] HIT_LAST    = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] PERIOD_FULL = 8'(INVADER_PERIOD);

  logic [2:0] state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [7:0] div_q, div_d;
  logic [7:0] period_q, period_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       hit_pend_q, hit_pend_d;
  logic       shoot_q;
  logic       player_en_q, player_en_d;
  logic       laser_en_q, laser_en_d;
  logic       invader_en_q, invader_en_d;
  logic       collide_en_q, collide_en_d;
  logic       game_rst_q, game_rst_d;

  logic       press_s;
  logic [7:0] frame_cnt_inc_s;
  logic [7:0] period_sel_s;

`ifdef SPEEDUP_EN
  // Number of alive invaders in the 55-entry mask.
  function automatic logic [5:0] popcount55(input logic [54:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 55; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

  // Fewer survivors march faster.
  function automatic logic [7:0] speed_period(input logic [5:0] alive);
    logic [7:0] p;
    if (alive >= 6'd40) begin
      p = PERIOD_FULL;
    end else if (alive >= 6'd20) begin
      p = PERIOD_FULL >> 1;
    end else if (alive >= 6'd5) begin
      p = PERIOD_FULL >> 2;
    end else begin
      p = 8'd1;
    end
    return p;
  endfunction

  assign period_sel_s = speed_period(popcount55(invaders));
`else
  assign period_sel_s = PERIOD_FULL;
`endif

  assign press_s         = shoot & ~shoot_q;
  assign frame_cnt_inc_s = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;

  // Next-state logic for the game FSM, frame phase sequencer and strobes.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    div_d        = div_q;
    period_d     = period_q;
    frame_cnt_d  = frame_cnt_q;
    hit_pend_d   = hit_pend_q;
    player_en_d  = 1'b0;
    laser_en_d   = 1'b0;
    invader_en_d = 1'b0;
    collide_en_d = 1'b0;
    game_rst_d   = 1'b0;

    case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (press_s) begin
          game_rst_d = 1'b1;
          state_d    = S_START;
        end else begin
          state_d = state_q;
        end
      end

      S_START: begin
        if (frame) begin
          if (frame_cnt_q == START_LAST) begin
            state_d    = S_PLAY;
            phase_d    = 3'd0;
            div_d      = 8'd0;
            period_d   = period_sel_s;
            hit_pend_d = 1'b0;
          end else begin
            frame_cnt_d = frame_cnt_inc_s;
          end
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end

      S_PLAY: begin
        if (player_collision) begin
          hit_pend_d = 1'b1;
        end else begin
          hit_pend_d = hit_pend_q;
        end
        // Each case arm raises the strobe that is visible during the next phase.
        case (phase_q)
          3'd0: begin
            if (frame) begin
              phase_d     = 3'd1;
              player_en_d = 1'b1;
            end else begin
              phase_d = 3'd0;
            end
          end
          3'd1: begin
            phase_d    = 3'd2;
            laser_en_d = 1'b1;
          end
          3'd2: begin
            phase_d = 3'd3;
            if (div_q == period_q - 8'd1) begin
              invader_en_d = 1'b1;
              div_d        = 8'd0;
              period_d     = period_sel_s;
            end else begin
              div_d = div_q + 8'd1;
            end
          end
          3'd3: begin
            phase_d      = 3'd4;
            collide_en_d = 1'b1;
          end
          3'd4: begin
            phase_d = 3'd5;
          end
          3'd5: begin
            // A collision pulse in this very cycle still counts as a hit.
            phase_d    = 3'd0;
            hit_pend_d = 1'b0;
            if (invaders_bottom >= LAND_Y) begin
              state_d = S_OVER;
            end else if (hit_pend_q | player_collision) begin
              state_d = S_HIT;
            end else if (invaders == 55'd0) begin
              state_d = S_WIN;
            end else begin
              state_d = S_PLAY;
            end
          end
          default: begin
            phase_d = 3'd0;
          end
        endcase
      end

      S_HIT: begin
        if (frame) begin
          if (frame_cnt_q == HIT_LAST) begin
            phase_d = 3'd0;
            if (lives == 2'd0) begin
              state_d = S_OVER;
            end else begin
              state_d = S_PLAY;
            end
          end else begin
            frame_cnt_d = frame_cnt_inc_s;
          end
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        phase_d = 3'd0;
      end
    endcase

    // Every state entry restarts the frame count.
    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else begin
      frame_cnt_d = frame_cnt_d;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 3'd0;
      div_q        <= 8'd0;
      period_q     <= PERIOD_FULL;
      frame_cnt_q  <= 8'd0;
      hit_pend_q   <= 1'b0;
      shoot_q      <= 1'b0;
      player_en_q  <= 1'b0;
      laser_en_q   <= 1'b0;
      invader_en_q <= 1'b0;
      collide_en_q <= 1'b0;
      game_rst_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      div_q        <= div_d;
      period_q     <= period_d;
      frame_cnt_q  <= frame_cnt_d;
      hit_pend_q   <= hit_pend_d;
      shoot_q      <= shoot;
      player_en_q  <= player_en_d;
      laser_en_q   <= laser_en_d;
      invader_en_q <= invader_en_d;
      collide_en_q <= collide_en_d;
      game_rst_q   <= game_rst_d;
    end
  end

  assign state      = state_q;
  assign player_en  = player_en_q;
  assign laser_en   = laser_en_q;
  assign invader_en = invader_en_q;
  assign collide_en = collide_en_q;
  assign game_rst   = game_rst_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed, scoreboard-based bench for game_sequencer (default parameters).
// Expected output vectors {state, game_rst, player, laser, invader, collide}
// are queued when stimulus is driven and popped/compared one per cycle.
module tb_game_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_HIT   = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;
  localparam logic [54:0] ALL_ALIVE = {55{1'b1}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame = 1'b0;
  logic        shoot = 1'b0;
  logic        player_collision = 1'b0;
  logic [54:0] invaders = ALL_ALIVE;
  logic [9:0]  invaders_bottom = 10'd100;
  logic [1:0]  lives = 2'd2;
  logic [2:0]  state;
  logic        player_en, laser_en, invader_en, collide_en, game_rst;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  div_m    = 0;
  int  period_m = 32;

  game_sequencer dut (
    .clk(clk), .rst(rst), .frame(frame), .shoot(shoot),
    .player_collision(player_collision), .invaders(invaders),
    .invaders_bottom(invaders_bottom), .lives(lives), .state(state),
    .player_en(player_en), .laser_en(laser_en), .invader_en(invader_en),
    .collide_en(collide_en), .game_rst(game_rst)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ev(input logic [2:0] st, input logic gr, input logic [3:0] strb);
    return {st, gr, strb};
  endfunction

  function automatic int model_period(input logic [54:0] v);
    int n;
    n = $countones(v);
`ifdef SPEEDUP_EN
    if (n >= 40) return 32;
    else if (n >= 20) return 16;
    else if (n >= 5) return 8;
    else return 1;
`else
    return (n >= 0) ? 32 : 32;
`endif
  endfunction

  task automatic push(input string tag, input logic [7:0] e);
    sb_t it;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic pop_check();
    sb_t it;
    logic [7:0] obs;
    obs = {state, game_rst, player_en, laser_en, invader_en, collide_en};
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%02h expected=<entry>", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%02h expected=%02h", it.tag, obs, it.exp);
      end
    end
  endtask

  // One cycle with the given expectation for the cycle that follows.
  task automatic step(input string tag, input logic [7:0] e);
    push(tag, e);
    @(negedge clk);
    pop_check();
  endtask

  task automatic press(input string tag);
    shoot = 1'b1;
    step(tag, ev(S_START, 1'b1, 4'b0000));
    shoot = 1'b0;
    step({tag, "_1cyc"}, ev(S_START, 1'b0, 4'b0000));
  endtask

  // n frame pulses 4 cycles apart; state st throughout, nxt after the last.
  task automatic hold_frames(input int n, input logic [2:0] st, input logic [2:0] nxt, input string tag);
    for (int i = 0; i < n; i++) begin
      frame = 1'b1;
      step(tag, ev((i == n - 1) ? nxt : st, 1'b0, 4'b0000));
      frame = 1'b0;
      if (i < n - 1) begin
        repeat (3) step(tag, ev(st, 1'b0, 4'b0000));
      end
    end
    if (st == S_START && nxt == S_PLAY) begin
      div_m    = 0;
      period_m = model_period(invaders);
    end
  endtask

  // One PLAY frame; pc_at = cycle offset of a collision pulse (-1 none).
  task automatic play_frame(input logic [2:0] nxt, input int pc_at, input bit drop, input string tag);
    logic inv;
    inv = (div_m == period_m - 1);
    if (inv) begin
      div_m    = 0;
      period_m = model_period(invaders);
    end else begin
      div_m = div_m + 1;
    end
    frame = 1'b1;
    player_collision = (pc_at == 0);
    push({tag, "_player"},  ev(S_PLAY, 1'b0, 4'b1000));
    push({tag, "_laser"},   ev(S_PLAY, 1'b0, 4'b0100));
    push({tag, "_invader"}, ev(S_PLAY, 1'b0, {2'b00, inv, 1'b0}));
    push({tag, "_collide"}, ev(S_PLAY, 1'b0, 4'b0001));
    push({tag, "_eval"},    ev(S_PLAY, 1'b0, 4'b0000));
    push({tag, "_state"},   ev(nxt, 1'b0, 4'b0000));
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      frame = drop && (j == 3);
      player_collision = (pc_at == j);
      pop_check();
    end
  endtask

  initial begin
    #1_000_000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    step("reset_state", ev(S_IDLE, 1'b0, 4'b0000));
    rst = 1'b1;
    step("idle_after_reset", ev(S_IDLE, 1'b0, 4'b0000));
    frame = 1'b1;
    step("idle_ignores_frame", ev(S_IDLE, 1'b0, 4'b0000));
    frame = 1'b0;

    press("press_idle");
    hold_frames(120, S_START, S_PLAY, "start_count");

    // Normal play: invader steps on every 32nd frame; one dropped frame pulse.
    for (int k = 0; k < 64; k++) begin
      play_frame(S_PLAY, -1, (k == 5), "play");
      if (k == 5) begin
        repeat (8) step("dropped_frame_quiet", ev(S_PLAY, 1'b0, 4'b0000));
      end
    end

`ifdef SPEEDUP_EN
    invaders = 55'h3FF;
    for (int k = 0; k < 48; k++) play_frame(S_PLAY, -1, 1'b0, "spd10");
    invaders = 55'h7;
    for (int k = 0; k < 16; k++) play_frame(S_PLAY, -1, 1'b0, "spd3");
    invaders = ALL_ALIVE;
`endif

    // Hit with lives left: freeze 90 frames, then resume.
    lives = 2'd2;
    play_frame(S_HIT, 0, 1'b0, "hit_lives2");
    hold_frames(90, S_HIT, S_PLAY, "hit_freeze");
    play_frame(S_PLAY, -1, 1'b0, "resume");

    // Hit arriving in the evaluation cycle, no lives left.
    lives = 2'd0;
    play_frame(S_HIT, 5, 1'b0, "hit_phase5");
    hold_frames(90, S_HIT, S_OVER, "hit_to_over");
    step("over_hold", ev(S_OVER, 1'b0, 4'b0000));

    // Restart, then wave cleared.
    press("press_over");
    hold_frames(120, S_START, S_PLAY, "start2");
    invaders = 55'd0;
    play_frame(S_WIN, -1, 1'b0, "win");
    step("win_hold", ev(S_WIN, 1'b0, 4'b0000));

    // Restart; a hit outranks a cleared wave.
    invaders = ALL_ALIVE;
    lives = 2'd2;
    press("press_win");
    hold_frames(120, S_START, S_PLAY, "start3");
    invaders = 55'd0;
    play_frame(S_HIT, 2, 1'b0, "hit_over_win");
    hold_frames(90, S_HIT, S_PLAY, "hit_freeze2");

    // Landing outranks both a hit and a cleared wave.
    invaders_bottom = 10'd440;
    play_frame(S_OVER, 1, 1'b0, "landing");

    // Restart and reset asynchronously during phase 2.
    invaders = ALL_ALIVE;
    invaders_bottom = 10'd100;
    press("press_land");
    hold_frames(120, S_START, S_PLAY, "start4");
    frame = 1'b1;
    step("rst_seq_player", ev(S_PLAY, 1'b0, 4'b1000));
    frame = 1'b0;
    step("rst_seq_laser", ev(S_PLAY, 1'b0, 4'b0100));
    rst = 1'b0;
    #1;
    push("async_reset", ev(S_IDLE, 1'b0, 4'b0000));
    pop_check();
    step("reset_held", ev(S_IDLE, 1'b0, 4'b0000));
    rst = 1'b1;
    repeat (6) step("after_reset_idle", ev(S_IDLE, 1'b0, 4'b0000));

    n_assert++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
